// File: rtl/mem_writeback_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and data memory (slave).
interface mem_writeback_stage_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [DATA_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [DATA_WIDTH-1:0] dmem_rdata;
    logic                  dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_writeback_stage.sv
// Memory-stage controller and MEM/WB register: redirect resolution, variable-latency data access.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_writeback_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                Jump_M,
    input  logic                      BranchEQ_M,
    input  logic                      BranchNE_M,
    input  logic                      Zero_M,
    input  logic                      MemRead_M,
    input  logic                      MemWrite_M,
    input  logic                      RegWrite_M,
    input  logic [1:0]                MemToReg_M,
    input  logic [DATA_WIDTH-1:0]     ALUResult_M,
    input  logic [DATA_WIDTH-1:0]     ReadData1_M,
    input  logic [DATA_WIDTH-1:0]     ReadData2_M,
    input  logic [DATA_WIDTH-1:0]     PCBranch_M,
    input  logic [DATA_WIDTH-1:0]     BranchAdderResult_M,
    input  logic [DATA_WIDTH-1:0]     ShiftLeft2_Jump_M,
    input  logic [REG_ADDR_WIDTH-1:0] WriteReg_M,
    mem_writeback_stage_if.master     dmem,
    output logic                      Stall,
    output logic                      PCSrc_M,
    output logic [DATA_WIDTH-1:0]     PCTarget_M,
    output logic                      RegWrite_W,
    output logic [REG_ADDR_WIDTH-1:0] WriteReg_W,
    output logic [DATA_WIDTH-1:0]     WriteData_W,
    output logic                      MemFault_W
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t                    r_state;
    logic                      r_req;
    logic                      r_we;
    logic [DATA_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH-1:0]     r_load_buf;
    logic                      r_wb_we;
    logic [REG_ADDR_WIDTH-1:0] r_wb_reg;
    logic [DATA_WIDTH-1:0]     r_wb_data;
    logic                      r_fault;

    logic                      w_mem_op;
    logic                      w_misaligned;
    logic                      w_start;
    logic                      w_taken;
    logic [DATA_WIDTH-1:0]     w_addr;
    logic [DATA_WIDTH-1:0]     w_wb_data;

    always_comb begin
        w_mem_op = MemRead_M | MemWrite_M;
`ifdef MEM_ALIGN_CHECK_EN
        w_misaligned = w_mem_op & (ALUResult_M[1:0] != 2'b00);
`else
        w_misaligned = 1'b0;
`endif
        w_start = (r_state == StIdle) & w_mem_op & ~w_misaligned;
        Stall   = w_start | (r_state == StBusy);

        // Word accesses only: low address bits never reach the bus.
        w_addr = ALUResult_M & {{(DATA_WIDTH-2){1'b1}}, 2'b00};

        w_taken = (BranchEQ_M & Zero_M) | (BranchNE_M & ~Zero_M) |
                  (Jump_M == 2'b01) | (Jump_M == 2'b10);
        PCSrc_M = w_taken & ~Stall;

        if (Jump_M == 2'b10) begin
            PCTarget_M = ReadData1_M;
        end else if (Jump_M == 2'b01) begin
            PCTarget_M = ShiftLeft2_Jump_M;
        end else begin
            PCTarget_M = BranchAdderResult_M;
        end

        case (MemToReg_M)
            2'b01:   w_wb_data = r_load_buf;
            2'b10:   w_wb_data = PCBranch_M;
            default: w_wb_data = ALUResult_M;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_load_buf <= '0;
            r_wb_we    <= 1'b0;
            r_wb_reg   <= '0;
            r_wb_data  <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_req   <= 1'b1;
                        r_we    <= MemWrite_M;
                        r_addr  <= w_addr;
                        r_wdata <= ReadData2_M;
                        r_wb_we <= 1'b0;
                        r_state <= StBusy;
                    end else if (w_misaligned) begin
                        r_wb_we <= 1'b0;
                        r_fault <= 1'b1;
                    end else begin
                        r_wb_we   <= RegWrite_M;
                        r_wb_reg  <= WriteReg_M;
                        r_wb_data <= w_wb_data;
                    end
                end
                StBusy: begin
                    if (dmem.dmem_ack) begin
                        r_load_buf <= dmem.dmem_rdata;
                        r_req      <= 1'b0;
                        r_state    <= StDone;
                    end
                end
                StDone: begin
                    // Upstream advances on this edge, so the instruction retires here.
                    r_wb_we   <= RegWrite_M;
                    r_wb_reg  <= WriteReg_M;
                    r_wb_data <= w_wb_data;
                    r_state   <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign RegWrite_W      = r_wb_we;
    assign WriteReg_W      = r_wb_reg;
    assign WriteData_W     = r_wb_data;
    assign MemFault_W      = r_fault;

endmodule
